mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address width of the attached datamemory.
REQ-002 Parameter DATA_WIDTH, default 32: data word width; only 32 is supported.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset (ports clk, rst).
REQ-004 clk  in  1  rising-edge clock shared with datamemory.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  CPU request present.
REQ-007 req_ready  out  1  unit accepts a request; accept = req_valid & req_ready.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  zero-extend load (lbu/lhu) when 1.
REQ-011 req_addr  in  32  byte address.
REQ-012 req_wdata  in  32  store data, right-justified.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-015 resp_misalign  out  1  fault flag, valid with resp_valid.
REQ-016 mem_address  out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2].
REQ-017 mem_dataIn  out  32  write data to memory.
REQ-018 mem_WR_RD  out  1  0 = write at next clk edge, 1 = read.
REQ-019 mem_dataOut  in  32  memory read data; valid one cycle after mem_address is presented.

Function
REQ-020 FSM states: IDLE, RD_WAIT (load data return), RMW (sub-word merge-write); req_ready=1 only in IDLE.
REQ-021 In IDLE, mem_address is driven combinationally from req_addr; in other states, from the registered request.
REQ-022 mem_WR_RD SHALL be 1 in every cycle except aligned word-store accept (IDLE) and the RMW state.
REQ-023 Byte order is big-endian: byte offset 0 = bits 31:24; half offset 0 = bits 31:16.
REQ-024 Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size 11; no memory write; resp_valid at T+1 with resp_misalign=1, resp_rdata=0; stay IDLE.
REQ-025 Word store accepted at T: write at T's edge with mem_dataIn=req_wdata; resp_valid at T+1; stay IDLE (back-to-back stores allowed).
REQ-026 Load accepted at T: state RD_WAIT at T+1; extract lane, sign/zero-extend, register; resp_valid and resp_rdata at T+2, state IDLE at T+2.
REQ-027 Sub-word store accepted at T: read issued at T; at T+1 (RMW), merge req_wdata low byte/half into mem_dataOut lane, drive mem_WR_RD=0; resp_valid at T+2, IDLE at T+2.
REQ-028 Address bits above ADDR_WIDTH+1 are ignored (wrap modulo memory size).
REQ-029 resp_valid is high for exactly one cycle per accepted request; resp_rdata holds its value until the next resp_valid.
REQ-030 req_* inputs are ignored when req_ready=0.

Reset
REQ-031 On rst: state IDLE, resp_valid=0, resp_misalign=0, resp_rdata=0, registered request cleared.
REQ-032 rst during IDLE accept or RMW SHALL force mem_WR_RD=1 in that cycle (no memory write).
REQ-033 rst has priority over any accept in the same cycle; an in-flight request produces no response.

Structure
REQ-034 Package mips_mem_pkg SHALL hold size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the FSM state type, and the misalign predicate.
REQ-035 One combinational sub-module, mem_lane_align, SHALL perform load extraction/extension and store merging; the FSM stays in mem_access_unit.

Verification (memory word 0 preloaded 0x000007D1)
REQ-036 lw addr 0x0 at T -> resp_valid T+2, resp_rdata=0x000007D1, misalign=0.
REQ-037 lb addr 0x3 -> 0xFFFFFFD1; lbu addr 0x3 -> 0x000000D1; lh addr 0x2 -> 0x000007D1.
REQ-038 sb addr 0x1 data 0xAB -> mem_WR_RD=0 only at T+1; then lw 0x0 returns 0x00AB07D1.
REQ-039 lw addr 0x2 and sh addr 0x1 -> resp_valid T+1, misalign=1, no cycle with mem_WR_RD=0.
REQ-040 sh addr 0x0 data 0x1234, rst asserted at T+1 -> no write, no resp_valid; lw 0x0 still returns 0x000007D1.
REQ-041 sw 0x1000 (wraps to word 0) data 0xDEADBEEF on two consecutive cycles -> two resp_valid pulses; lw 0x0 returns 0xDEADBEEF.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the CPU-side data memory access path.
// Holds access-size encodings, FSM state type, request record and the alignment predicate.
// No logic here; consumers are mem_access_unit and mem_lane_align.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW     = 2'd2
  } state_e;

  // Request fields that must survive past the accept cycle. Only the low
  // half of the store data is kept: word stores complete in the accept cycle.
  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [15:0] wdata;
  } req_t;

  // True when the access cannot be served: half on odd address, word not on
  // a 4-byte boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a big-endian memory word and CPU load/store data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs every cycle.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] mem_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [4:0]  sh;

  // Offset 0 is the most significant lane, so lanes move right as offset grows.
  assign sh = {off, 3'b000};

  // Pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = off[1] ? mem_word[15:0] : mem_word[31:16];
    case (off)
      2'd0:    byte_lane = mem_word[31:24];
      2'd1:    byte_lane = mem_word[23:16];
      2'd2:    byte_lane = mem_word[15:8];
      default: byte_lane = mem_word[7:0];
    endcase
    case (size)
      SZ_BYTE: load_data = uns ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = uns ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = mem_word;
    endcase
  end

  // Overlay the low byte/half of the store data onto the addressed lane.
  always_comb begin
    mask = 32'h0000_0000;
    ins  = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        mask = 32'hFF00_0000 >> sh;
        ins  = {wdata[7:0], 24'h000000} >> sh;
      end
      SZ_HALF: begin
        mask = 32'hFFFF_0000 >> sh;
        ins  = {wdata, 16'h0000} >> sh;
      end
      default: ;
    endcase
    store_word = (mem_word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a CPU request port and a synchronous single-port word memory.
// Latency: word store / fault respond at T+1; loads and sub-word stores (read-merge-write) at T+2.
// Backpressure: req_ready is high only in IDLE; requests offered while busy are ignored.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misalign,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_WR_RD,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  state_e      state_q, state_d;
  req_t        req_q;
  logic        accept;
  logic        misalign_in;
  logic        word_store;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        unused_addr_bits;

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign misalign_in = is_misaligned(req_size, req_addr[1:0]);
  assign word_store  = req_we && (req_size == SZ_WORD);

  // Address bits above the memory size wrap and are deliberately dropped.
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_q.addr[31:ADDR_WIDTH+2]};

  mem_lane_align u_align (
    .size       (req_q.size),
    .uns        (req_q.uns),
    .off        (req_q.addr[1:0]),
    .mem_word   (mem_dataOut),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next state and memory port drive; reset always suppresses a write.
  always_comb begin
    state_d     = state_q;
    mem_WR_RD   = 1'b1;
    mem_address = req_q.addr[ADDR_WIDTH+1:2];
    mem_dataIn  = store_word;
    case (state_q)
      IDLE: begin
        mem_address = req_addr[ADDR_WIDTH+1:2];
        mem_dataIn  = req_wdata;
        if (accept && !misalign_in) begin
          if (word_store)   mem_WR_RD = 1'b0;
          else if (req_we)  state_d   = RMW;
          else              state_d   = RD_WAIT;
        end
      end
      RD_WAIT: state_d = IDLE;
      RMW: begin
        mem_WR_RD = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) mem_WR_RD = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the request on accept for use in the follow-up cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.size  <= req_size;
      req_q.uns   <= req_unsigned;
      req_q.addr  <= req_addr;
      req_q.wdata <= req_wdata[15:0];
    end
  end

  // Completion pulse; read data holds until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_misalign <= 1'b0;
      resp_rdata    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept && (misalign_in || word_store)) begin
        resp_valid    <= 1'b1;
        resp_misalign <= misalign_in;
        resp_rdata    <= '0;
      end else if (state_q == RD_WAIT) begin
        resp_valid    <= 1'b1;
        resp_misalign <= 1'b0;
        resp_rdata    <= load_data;
      end else if (state_q == RMW) begin
        resp_valid    <= 1'b1;
        resp_misalign <= 1'b0;
        resp_rdata    <= '0;
      end
    end
  end

endmodule
